// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host receiver that folds E0/F0 prefixes into single key events
// Ports: CLOCK_50 system clock, reset sync active-high; PS2_CLK/PS2_DAT raw keyboard pins;
//        byte_data/byte_valid last good raw byte; key_code/key_ext/key_release/key_valid folded
//        key event; frame_err bad start/parity/stop/timeout pulse; busy while a frame is open.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        r_state, w_state_nx;
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_flt_clk;
    logic [FW-1:0] r_flt_cnt;
    logic [WW-1:0] r_wdog;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_sh, r_byte_data, r_key_code;
    logic          r_par, r_byte_valid, r_key_valid, r_key_ext, r_key_release;
    logic          r_frame_err, r_ext_pend, r_brk_pend;
    logic          w_clk_s, w_dat_s, w_fall, w_timeout, w_good, w_bad;
    assign w_clk_s   = r_clk_sync[1];
    assign w_dat_s   = r_dat_sync[1];
    // fall is the cycle in which the filter accepts a low clock that it has seen FILTER_LEN times
    assign w_fall    = r_flt_clk & ~w_clk_s & (r_flt_cnt == FW'(FILTER_LEN - 1));
    // frame_err is registered, so trip one cycle early to land exactly TIMEOUT_CYC-1 after the fall
    assign w_timeout = (r_state != IDLE) && (r_wdog == WW'(TIMEOUT_CYC - 2));
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_flt_clk  <= 1'b1;
            r_flt_cnt  <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            if (w_clk_s == r_flt_clk) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_flt_clk <= w_clk_s;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
            end
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end
    always_comb begin
        w_state_nx = r_state;
        w_good     = 1'b0;
        w_bad      = 1'b0;
        if (w_timeout) begin
            w_state_nx = IDLE;
            w_bad      = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    begin
                    w_state_nx = w_dat_s ? IDLE : DATA;
                    w_bad      = w_dat_s;
                end
                DATA:    w_state_nx = (r_bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  w_state_nx = STOP;
                STOP:    begin
                    w_state_nx = IDLE;
                    w_good     = w_dat_s & (^{r_sh, r_par});
                    w_bad      = ~(w_dat_s & (^{r_sh, r_par}));
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wdog        <= '0;
            r_bit_cnt     <= '0;
            r_sh          <= '0;
            r_par         <= 1'b0;
            r_byte_data   <= '0;
            r_byte_valid  <= 1'b0;
            r_key_code    <= '0;
            r_key_ext     <= 1'b0;
            r_key_release <= 1'b0;
            r_key_valid   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_ext_pend    <= 1'b0;
            r_brk_pend    <= 1'b0;
        end else begin
            r_byte_valid <= w_good;
            r_key_valid  <= 1'b0;
            r_frame_err  <= w_bad;
            // counts cycles since the last fall while a frame is open
            r_wdog <= (w_state_nx == IDLE) ? '0 : w_fall ? WW'(1) : r_wdog + WW'(1);
            if (w_fall && !w_timeout) begin
                if (r_state == IDLE) r_bit_cnt <= '0;
                if (r_state == DATA) begin
                    r_sh      <= {w_dat_s, r_sh[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (r_state == PARITY) r_par <= w_dat_s;
            end
            if (w_bad) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
            if (w_good) begin
                r_byte_data <= r_sh;
                if (r_sh == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_sh == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_key_code    <= r_sh;
                    r_key_ext     <= r_ext_pend;
                    r_key_release <= r_brk_pend;
                    r_key_valid   <= 1'b1;
                    r_ext_pend    <= 1'b0;
                    r_brk_pend    <= 1'b0;
                end
            end
        end
    end
    assign byte_data   = r_byte_data;
    assign byte_valid  = r_byte_valid;
    assign key_code    = r_key_code;
    assign key_ext     = r_key_ext;
    assign key_release = r_key_release;
    assign key_valid   = r_key_valid;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: randomized and directed bench for ps2_keyboard_rx against a frame-level key decoder model
module tb_ps2_keyboard_rx;
    localparam int TO = 300;
    localparam int FL = 8;
    localparam int HP = 20;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic [7:0] byte_data, key_code;
    logic byte_valid, key_ext, key_release, key_valid, frame_err, busy;
    int cyc = 0, errors = 0, checks = 0, fall_cyc = 0, last_bv_cyc = 0;
    logic [11:0] got_q[$], exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0;
    logic [7:0] m_last = 8'h00;

    ps2_keyboard_rx #(.TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
        .CLOCK_50(clk), .reset(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .byte_data(byte_data), .byte_valid(byte_valid), .key_code(key_code),
        .key_ext(key_ext), .key_release(key_release), .key_valid(key_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // event encoding: 0=byte, 1=key {rel,ext,code}, 2=error, 3=key without matching byte pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                got_q.push_back({4'h0, byte_data});
                last_bv_cyc <= cyc;
            end
            if (key_valid) got_q.push_back({byte_valid ? 2'd1 : 2'd3, key_release, key_ext, key_code});
            if (frame_err) got_q.push_back(12'h800);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_flip, input bit stop_bad);
        return {~stop_bad, ~(^b) ^ par_flip, b, 1'b0};
    endfunction

    // model: each frame is either a good byte or an error; prefixes accumulate until a plain code
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_q.push_back(12'h800);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            exp_q.push_back({4'h0, b});
            m_last = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                exp_q.push_back({2'd1, m_brk, m_ext, b});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_dat = bits[i];
            repeat (HP / 2) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HP / 2) @(negedge clk);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad);
        send_bits(frame_bits(b, par_flip, stop_bad), 11);
        repeat (HP) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data got=%h exp=00", byte_data); end
        if (key_code !== 8'h00) begin errors++; $display("FAIL reset_key_code got=%h exp=00", key_code); end
        if ({byte_valid, key_valid, key_ext, key_release, frame_err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000", {byte_valid, key_valid, key_ext, key_release, frame_err, busy});
        end
        repeat (50) @(negedge clk);
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL reset_quiet got=%0d events exp=0", got_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        got_q.delete();
    endtask

    task automatic test_single_make;
        send_frame(8'h1C, 0, 0);
        model_frame(8'h1C, 1);
        checks += 3;
        if (last_bv_cyc - fall_cyc !== FL + 2) begin
            errors++;
            $display("FAIL make_latency got=%0d exp=%0d", last_bv_cyc - fall_cyc, FL + 2);
        end
        if (byte_data !== 8'h1C) begin errors++; $display("FAIL make_byte_data got=%h exp=1c", byte_data); end
        if ({key_code, key_ext, key_release} !== {8'h1C, 2'b00}) begin
            errors++;
            $display("FAIL make_key got=%h/%b/%b exp=1c/0/0", key_code, key_ext, key_release);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL make_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL make_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_break;
        send_frame(8'hF0, 0, 0);
        model_frame(8'hF0, 1);
        send_frame(8'h1C, 0, 0);
        model_frame(8'h1C, 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL break_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL break_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_extended;
        send_frame(8'hE0, 0, 0);
        model_frame(8'hE0, 1);
        send_frame(8'hF0, 0, 0);
        model_frame(8'hF0, 1);
        send_frame(8'h75, 0, 0);
        model_frame(8'h75, 1);
        send_frame(8'h75, 0, 0);
        model_frame(8'h75, 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ext_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ext_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_errors;
        send_frame(8'h1C, 1, 0);
        model_frame(8'h1C, 0);
        checks++;
        if (byte_data !== m_last) begin errors++; $display("FAIL err_byte_kept got=%h exp=%h", byte_data, m_last); end
        send_frame(8'hF0, 0, 0);
        model_frame(8'hF0, 1);
        send_frame(8'h33, 0, 1);
        model_frame(8'h33, 0);
        send_frame(8'h1C, 0, 0);
        model_frame(8'h1C, 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL err_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL err_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout;
        bit found;
        int err_cyc;
        logic busy_at, prev_busy;
        found     = 1'b0;
        err_cyc   = 0;
        busy_at   = 1'bx;
        prev_busy = 1'bx;
        send_bits(frame_bits(8'h29, 0, 0), 5);
        for (int k = 0; k < TO + 100 && !found; k++) begin
            @(negedge clk);
            if (frame_err) begin
                found   = 1'b1;
                err_cyc = cyc;
                busy_at = busy;
            end else begin
                prev_busy = busy;
            end
        end
        model_frame(8'h00, 0);
        checks += 4;
        if (!found) begin errors++; $display("FAIL timeout_seen got=none exp=frame_err"); end
        if (err_cyc - fall_cyc !== FL + 1 + TO - 1) begin
            errors++;
            $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - fall_cyc, FL + 1 + TO - 1);
        end
        if (busy_at !== 1'b0) begin errors++; $display("FAIL timeout_busy_low got=%b exp=0", busy_at); end
        if (prev_busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got=%b exp=1", prev_busy); end
        send_frame(8'h29, 0, 0);
        model_frame(8'h29, 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] fb;
        fb = frame_bits(8'h00, 0, 0);
        send_bits(fb, 4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 2;
        if ({byte_data, key_code} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_data got=%h/%h exp=00/00", byte_data, key_code);
        end
        if ({byte_valid, key_valid, key_ext, key_release, frame_err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_flags got=%b exp=000000", {byte_valid, key_valid, key_ext, key_release, frame_err, busy});
        end
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_last = 8'h00;
        got_q.delete();
        exp_q.delete();
        send_bits(fb >> 4, 7);
        repeat (TO + 50) @(negedge clk);
        model_frame(8'h00, 0);
        send_frame(8'h5A, 0, 0);
        model_frame(8'h5A, 1);
        checks += 2;
        if (byte_data !== 8'h5A) begin errors++; $display("FAIL mid_byte_data got=%h exp=5a", byte_data); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        int r;
        logic [7:0] b;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            case (r)
                0: begin send_frame(b, 1, 0); model_frame(b, 0); end
                1: begin send_frame(b, 0, 1); model_frame(b, 0); end
                2: begin send_bits(11'h7FF, 1); repeat (HP) @(negedge clk); model_frame(b, 0); end
                3: begin send_frame(8'hE0, 0, 0); model_frame(8'hE0, 1); end
                4: begin send_frame(8'hF0, 0, 0); model_frame(8'hF0, 1); end
                default: begin send_frame(b, 0, 0); model_frame(b, 1); end
            endcase
        end
        checks += 2;
        if (byte_data !== m_last) begin errors++; $display("FAIL rand_byte_data got=%h exp=%h", byte_data, m_last); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_single_make;
        test_break;
        test_extended;
        test_errors;
        test_timeout;
        test_reset_mid_frame;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
